// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out capture path.
// Imported by the shift register and the word controller.
package sipo_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit left shifter; new bits enter at the LSB.
// Holds its contents whenever shift_en is low.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             d_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], d_in};
    end
  end

endmodule

// File: rtl/sipo_word_ctrl.sv
// Frame-aligned serial word capture with a single-entry
// valid/ready output register and a sticky overrun flag.
module sipo_word_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic             take;
  logic             start;
  logic             done;
  logic             drop;
  logic [WIDTH-1:0] word;

  assign start = en & s_valid & s_start;
  assign take  = en & s_valid
               & (s_start | (state == SHIFT));
  assign done  = take & ~s_start
               & (state == SHIFT)
               & (bit_cnt == LAST);
  assign word  = {q[WIDTH-2:0], s_in};
  assign drop  = done & p_valid & ~p_ready;

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (take),
    .d_in     (s_in),
    .q        (q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      // Start in IDLE and resync in SHIFT look alike.
      state   <= SHIFT;
      bit_cnt <= CNT_W'(1);
      busy    <= 1'b1;
    end else if (done) begin
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (take) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_data  <= '0;
      p_valid <= 1'b0;
    end else if (done && !drop) begin
      p_data  <= word;
      p_valid <= 1'b1;
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_word_ctrl.sv
// Directed bench for sipo_word_ctrl at WIDTH=4.
// Inputs change 1ns after a rising edge; outputs are sampled there.
module tb_sipo_word_ctrl;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          s_in = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_start = 1'b0;
  logic [W-1:0]  p_data;
  logic          p_valid;
  logic          p_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
  logic          clr_ovr = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_word_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .s_in    (s_in),
    .s_valid (s_valid),
    .s_start (s_start),
    .p_data  (p_data),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .busy    (busy),
    .bit_cnt (bit_cnt),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic st);
    s_in    = b;
    s_valid = 1'b1;
    s_start = st;
    tick();
    s_valid = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic frame(input logic [3:0] w);
    send(w[3], 1'b1);
    send(w[2], 1'b0);
    send(w[1], 1'b0);
    send(w[0], 1'b0);
  endtask

  initial begin
    #12;
    check("rst_pvalid", p_valid, 0);
    check("rst_pdata", p_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", bit_cnt, 0);
    check("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    en = 1'b1;
    p_ready = 1'b1;
    tick();

    // basic word 1011
    send(1'b1, 1'b1);
    check("b_busy1", busy, 1);
    check("b_cnt1", bit_cnt, 1);
    send(1'b0, 1'b0);
    check("b_cnt2", bit_cnt, 2);
    send(1'b1, 1'b0);
    check("b_cnt3", bit_cnt, 3);
    check("b_pv_early", p_valid, 0);
    send(1'b1, 1'b0);
    check("b_pvalid", p_valid, 1);
    check("b_pdata", p_data, 4'b1011);
    check("b_busy_end", busy, 0);
    check("b_cnt_end", bit_cnt, 0);
    tick();
    check("b_pv_once", p_valid, 0);

    // backpressure and overrun
    p_ready = 1'b0;
    frame(4'b1010);
    check("o_pv1", p_valid, 1);
    check("o_pd1", p_data, 4'b1010);
    frame(4'b0110);
    check("o_pd_hold", p_data, 4'b1010);
    check("o_pv_hold", p_valid, 1);
    check("o_ovr_set", overrun, 1);
    p_ready = 1'b1;
    tick();
    check("o_pv_drop", p_valid, 0);
    check("o_ovr_sticky", overrun, 1);
    p_ready = 1'b0;
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("o_ovr_clr", overrun, 0);

    // consume and complete in the same cycle
    frame(4'b1010);
    check("c_pd1", p_data, 4'b1010);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    p_ready = 1'b1;
    send(1'b1, 1'b0);
    check("c_pd2", p_data, 4'b0011);
    check("c_pv2", p_valid, 1);
    check("c_ovr", overrun, 0);
    tick();
    check("c_pv_drop", p_valid, 0);

    // resync with gaps
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    check("r_cnt2", bit_cnt, 2);
    send(1'b1, 1'b1);
    check("r_cnt_rs", bit_cnt, 1);
    check("r_busy", busy, 1);
    tick();
    check("r_gap1", bit_cnt, 1);
    send(1'b0, 1'b0);
    tick();
    check("r_gap2", bit_cnt, 2);
    send(1'b0, 1'b0);
    tick();
    check("r_gap3", bit_cnt, 3);
    check("r_pv_early", p_valid, 0);
    send(1'b1, 1'b0);
    check("r_pdata", p_data, 4'b1001);
    check("r_pvalid", p_valid, 1);
    check("r_ovr", overrun, 0);
    tick();

    // abort via en
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    check("a_cnt2", bit_cnt, 2);
    en = 1'b0;
    tick();
    en = 1'b1;
    check("a_busy", busy, 0);
    check("a_cnt0", bit_cnt, 0);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    check("a_ign_busy", busy, 0);
    check("a_ign_cnt", bit_cnt, 0);
    check("a_ign_pv", p_valid, 0);

    // async reset mid-word
    p_ready = 1'b0;
    frame(4'b1100);
    frame(4'b0101);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    check("x_pre_pv", p_valid, 1);
    check("x_pre_ovr", overrun, 1);
    check("x_pre_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("x_pv", p_valid, 0);
    check("x_pd", p_data, 0);
    check("x_ovr", overrun, 0);
    check("x_busy", busy, 0);
    check("x_cnt", bit_cnt, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
